// File: rtl/spi_cmd_engine.sv
`default_nettype none
// ============================================================================
// Module  : spi_cmd_engine
// Brief   : Command/register stage behind the SPI slave byte shifter. Decodes
//           a command byte plus an address, then reads or writes a small byte
//           register file. Returns the next MISO byte one clock after each
//           accepted byte or frame start.
// Revision: 1.0  initial release
// ============================================================================
module spi_cmd_engine #(
  parameter int         ADDR_W   = 4,
  parameter logic [7:0] ID_VALUE = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_start,
  input  logic       frame_end,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  output logic [7:0] tx_byte,
  output logic       tx_valid,
  output logic       led,
  output logic [7:0] err_cnt,
  output logic       busy
);

  localparam int              c_DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] c_ADDR_ONE = ADDR_W'(1);
  localparam logic [7:0]      c_CMD_WR   = 8'h02;
  localparam logic [7:0]      c_CMD_RD   = 8'h03;
  localparam logic [7:0]      c_CMD_ID   = 8'h9F;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CMD     = 3'd1,
    S_ADDR    = 3'd2,
    S_WR_DATA = 3'd3,
    S_RD_DATA = 3'd4,
    S_ID      = 3'd5,
    S_IGNORE  = 3'd6
  } state_t;

  state_t              r_state;
  logic                r_is_read;
  logic [ADDR_W-1:0]   r_addr;
  logic [7:0]          r_tx_byte;
  logic                r_tx_valid;
  logic [7:0]          r_err_cnt;
  logic [7:0]          r_regfile [c_DEPTH];

  state_t              w_state_nxt;
  logic                w_is_read_nxt;
  logic [ADDR_W-1:0]   w_addr_nxt;
  logic [7:0]          w_tx_byte_nxt;
  logic                w_tx_valid_nxt;
  logic                w_we;
  logic                w_err_inc;
  logic [ADDR_W-1:0]   w_rx_addr;

  // Only the low address bits of the address byte are meaningful.
  assign w_rx_addr = rx_byte[ADDR_W-1:0];

  // Next-state and datapath decode; frame_start overrides any byte in the same cycle.
  always_comb begin
    w_state_nxt    = r_state;
    w_is_read_nxt  = r_is_read;
    w_addr_nxt     = r_addr;
    w_tx_byte_nxt  = r_tx_byte;
    w_tx_valid_nxt = 1'b0;
    w_we           = 1'b0;
    w_err_inc      = 1'b0;

    if (frame_start) begin
      w_state_nxt    = S_CMD;
      w_is_read_nxt  = 1'b0;
      w_tx_byte_nxt  = 8'h00;
      w_tx_valid_nxt = 1'b1;
    end else begin
      if (rx_valid && (r_state != S_IDLE)) begin
        w_tx_valid_nxt = 1'b1;
        case (r_state)
          S_CMD: begin
            w_tx_byte_nxt = 8'h00;
            if (rx_byte == c_CMD_WR) begin
              w_is_read_nxt = 1'b0;
              w_state_nxt   = S_ADDR;
            end else if (rx_byte == c_CMD_RD) begin
              w_is_read_nxt = 1'b1;
              w_state_nxt   = S_ADDR;
            end else if (rx_byte == c_CMD_ID) begin
              w_tx_byte_nxt = ID_VALUE;
              w_state_nxt   = S_ID;
            end else begin
              w_err_inc   = 1'b1;
              w_state_nxt = S_IGNORE;
            end
          end
          S_ADDR: begin
            if (r_is_read) begin
              w_tx_byte_nxt = r_regfile[w_rx_addr];
              w_addr_nxt    = w_rx_addr + c_ADDR_ONE;
              w_state_nxt   = S_RD_DATA;
            end else begin
              w_tx_byte_nxt = 8'h00;
              w_addr_nxt    = w_rx_addr;
              w_state_nxt   = S_WR_DATA;
            end
          end
          S_WR_DATA: begin
            w_we          = 1'b1;
            w_tx_byte_nxt = rx_byte;
            w_addr_nxt    = r_addr + c_ADDR_ONE;
          end
          S_RD_DATA: begin
            w_tx_byte_nxt = r_regfile[r_addr];
            w_addr_nxt    = r_addr + c_ADDR_ONE;
          end
          S_ID:     w_tx_byte_nxt = ID_VALUE;
          S_IGNORE: w_tx_byte_nxt = 8'h00;
          default:  w_state_nxt   = S_IDLE;
        endcase
      end
      // A byte arriving with frame_end is fully processed before returning to idle.
      if (frame_end) begin
        w_state_nxt = S_IDLE;
      end
    end
  end

  // Control state, address pointer, response byte and error counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_is_read  <= 1'b0;
      r_addr     <= '0;
      r_tx_byte  <= 8'h00;
      r_tx_valid <= 1'b0;
      r_err_cnt  <= 8'h00;
    end else begin
      r_state    <= w_state_nxt;
      r_is_read  <= w_is_read_nxt;
      r_addr     <= w_addr_nxt;
      r_tx_byte  <= w_tx_byte_nxt;
      r_tx_valid <= w_tx_valid_nxt;
      if (w_err_inc && (r_err_cnt != 8'hFF)) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
    end
  end

  // Register file: cleared on reset, one byte written per accepted write-data byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < c_DEPTH; i++) begin
        r_regfile[i] <= 8'h00;
      end
    end else if (w_we) begin
      r_regfile[r_addr] <= rx_byte;
    end
  end

  assign tx_byte  = r_tx_byte;
  assign tx_valid = r_tx_valid;
  assign led      = r_regfile[0][0];
  assign err_cnt  = r_err_cnt;
  assign busy     = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_spi_cmd_engine.sv
`default_nettype none
// ============================================================================
// Module  : tb_spi_cmd_engine
// Brief   : Directed bench for spi_cmd_engine. Expected MISO bytes go into a
//           queue as stimulus is issued; a monitor pops one per tx_valid.
// Revision: 1.0  initial release
// ============================================================================
module tb_spi_cmd_engine;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_start = 1'b0;
  logic       frame_end = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic [7:0] tx_byte;
  logic       tx_valid;
  logic       led;
  logic [7:0] err_cnt;
  logic       busy;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_q [$];

  spi_cmd_engine #(.ADDR_W(4), .ID_VALUE(8'hA5)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .frame_end(frame_end),
    .rx_valid(rx_valid), .rx_byte(rx_byte), .tx_byte(tx_byte),
    .tx_valid(tx_valid), .led(led), .err_cnt(err_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  // Monitor: every tx_valid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (tx_valid) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL tx_unexpected: got tx_valid with tx_byte=%02h, required no tx_valid", tx_byte);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (tx_byte !== e) begin
          n_err++;
          $display("FAIL tx_byte: got %02h, required %02h", tx_byte, e);
        end
      end
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %02h, required %02h", name, act, req);
    end
  endtask

  // All drive tasks begin and end 1 time unit after a rising edge.
  task automatic start_frame();
    frame_start = 1'b1;
    exp_q.push_back(8'h00);
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input logic [7:0] e);
    rx_valid = 1'b1; rx_byte = b;
    exp_q.push_back(e);
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_last(input logic [7:0] b, input logic [7:0] e);
    rx_valid = 1'b1; rx_byte = b; frame_end = 1'b1;
    exp_q.push_back(e);
    @(posedge clk); #1;
    rx_valid = 1'b0; frame_end = 1'b0;
  endtask

  task automatic bare_byte(input logic [7:0] b);
    rx_valid = 1'b1; rx_byte = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic end_frame();
    frame_end = 1'b1;
    @(posedge clk); #1;
    frame_end = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    // 1: reset
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_tx_byte", tx_byte, 8'h00);
    check("rst_tx_valid", {7'd0, tx_valid}, 8'h00);
    check("rst_led", {7'd0, led}, 8'h00);
    check("rst_err_cnt", err_cnt, 8'h00);
    check("rst_busy", {7'd0, busy}, 8'h00);

    // 2: write 5,6 then read back (reg7 still 00)
    start_frame(); send(8'h02, 8'h00); send(8'h05, 8'h00);
    send(8'hAA, 8'hAA); send(8'hBB, 8'hBB); end_frame();
    idle(1);
    start_frame(); send(8'h03, 8'h00); send(8'h05, 8'hAA);
    send(8'h00, 8'hBB); send(8'h00, 8'h00); end_frame();
    idle(1);

    // 3: address wrap 15 -> 0, then LED
    start_frame(); send(8'h02, 8'h00); send(8'h0F, 8'h00);
    send(8'h11, 8'h11); send(8'h22, 8'h22); end_frame();
    check("led_after_22", {7'd0, led}, 8'h00);
    start_frame(); send(8'h03, 8'h0F ^ 8'h0F); // command byte response
    send(8'h0F, 8'h11); send(8'h00, 8'h22); end_frame();
    start_frame(); send(8'h02, 8'h00); send(8'h00, 8'h00);
    check("led_before_01", {7'd0, led}, 8'h00);
    send(8'h01, 8'h01);
    check("led_after_01", {7'd0, led}, 8'h01);
    end_frame();

    // 4: unknown command, error counter saturation
    start_frame(); send(8'h55, 8'h00); send(8'h77, 8'h00); end_frame();
    check("err_cnt_1", err_cnt, 8'h01);
    for (int i = 0; i < 253; i++) begin
      start_frame(); send(8'h55, 8'h00); end_frame();
    end
    check("err_cnt_FE", err_cnt, 8'hFE);
    for (int i = 0; i < 46; i++) begin
      start_frame(); send(8'h55, 8'h00); end_frame();
    end
    check("err_cnt_FF", err_cnt, 8'hFF);
    start_frame(); send(8'h03, 8'h00); send(8'h05, 8'hAA); send(8'h00, 8'hBB); end_frame();

    // Byte arriving with frame_end is committed
    start_frame(); send(8'h02, 8'h00); send(8'h08, 8'h00); send_last(8'h5A, 8'h5A);
    check("busy_after_end", {7'd0, busy}, 8'h00);
    start_frame(); send(8'h03, 8'h00); send(8'h08, 8'h5A); end_frame();

    // 5: bytes after frame_end are ignored
    start_frame(); send(8'h02, 8'h00); send(8'h03, 8'h00); end_frame();
    bare_byte(8'h99);
    idle(1);
    check("busy_idle", {7'd0, busy}, 8'h00);
    start_frame(); send(8'h03, 8'h00); send(8'h03, 8'h00); end_frame();

    // Reset mid-frame, with a coincident byte, then a stray byte
    start_frame(); send(8'h03, 8'h00); send(8'h00, 8'h01);
    rst = 1'b1; rx_valid = 1'b1; rx_byte = 8'h00;
    @(posedge clk); #1;
    rst = 1'b0; rx_valid = 1'b0;
    check("rst_mid_busy", {7'd0, busy}, 8'h00);
    check("rst_mid_led", {7'd0, led}, 8'h00);
    check("rst_mid_err", err_cnt, 8'h00);
    bare_byte(8'h55);
    idle(1);
    check("stray_err", err_cnt, 8'h00);

    // 6: ID command, and frame_start beating a coincident byte
    start_frame(); send(8'h9F, 8'hA5); send(8'h00, 8'hA5); send(8'h00, 8'hA5); end_frame();
    frame_start = 1'b1; rx_valid = 1'b1; rx_byte = 8'h02;
    exp_q.push_back(8'h00);
    @(posedge clk); #1;
    frame_start = 1'b0; rx_valid = 1'b0;
    check("fs_rx_busy", {7'd0, busy}, 8'h01);
    send(8'h9F, 8'hA5);
    end_frame();

    idle(3);
    check("queue_drained", 8'(exp_q.size()), 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
